instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage sitting directly downstream of the instruction memory (16-bit words, 1-cycle registered read).
//  Drives the memory address from a program counter and assembles opcode + optional 16-bit operand word.
//  Hands complete instructions to the decoder over a valid/ready handshake and accepts PC redirects from execute.
//  Detects endop and halts fetching.
// PARAMETERS
//  ADDR_W    16      PC / memory address width
//  DATA_W    16      instruction word width
//  RESET_PC  16'd0   PC value after reset
// PORTS
//  clk             in   1       clock; all state updates on posedge
//  rst             in   1       asynchronous, active-high reset
//  fetch_en        in   1       allow new fetches
//  imem_addr       out  ADDR_W  address to instruction memory (combinational from state/pc)
//  imem_rdata      in   DATA_W  word read for the address presented in the previous cycle
//  instr_valid     out  1       instruction outputs valid
//  instr_ready     in   1       decoder accepts the instruction
//  instr_opcode    out  8       opcode = low 8 bits of the first word
//  instr_operand   out  DATA_W  second word; 0 for single-word instructions
//  instr_has_opnd  out  1       instruction carried an operand word
//  instr_pc        out  ADDR_W  address of the opcode word
//  redirect_valid  in   1       execute-stage PC redirect (taken jump)
//  redirect_pc     in   ADDR_W  redirect target
//  halted          out  1       endop accepted; fetching stopped
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC; instr_valid=0, instr_opcode=0, instr_operand=0, instr_has_opnd=0, instr_pc=0, halted=0.
//  Two-word opcodes: loadim(38), jumpz(41), jumpnz(48), jump(49); all other opcodes are one word.
//  States:
//   IDLE: imem_addr=pc. fetch_en=1 -> OPC.
//   OPC:  imem_rdata=mem[pc]; latch opcode, instr_pc<=pc; imem_addr=pc+1.
//         two-word -> IMM; else pc<=pc+1, operand<=0 -> OUT.
//   IMM:  imem_rdata=mem[pc+1]; latch operand; pc<=pc+2 -> OUT.
//   OUT:  instr_valid=1; imem_addr=pc (prefetch of next opcode); outputs held stable while instr_ready=0.
//         On handshake: endop(51) -> HALT; else fetch_en ? OPC : IDLE.
//   HALT: halted=1, instr_valid=0, imem_addr=pc; only rst leaves HALT (redirect ignored).
//  Latency from entering OPC to instr_valid: 1 cycle (one-word), 2 cycles (two-word). Back-to-back throughput: one instruction per 2/3 cycles.
//  Redirect (any state but HALT): pc<=redirect_pc, discard in-flight/held instruction, instr_valid=0 next cycle, -> IDLE.
//   Redirect coincident with a handshake: instruction counts as consumed; redirect still wins; endop check is skipped.
//  fetch_en falling mid-instruction: current instruction completes; no new OPC entry.
//  PC arithmetic is modulo 2^ADDR_W: operand of an opcode at 0xFFFF is read from 0x0000.
//  imem_rdata upper byte on the opcode word is ignored (unless the trap below is enabled).
//  rst mid-operation: all state returns to reset values immediately; partial instructions are dropped.
// CONFIGURATION
//  IFETCH_ILLEGAL_TRAP_EN defined: opcode word not in the ISA set, or with nonzero upper byte -> extra output
//   illegal_op (1 bit, reset 0) is set in OUT alongside instr_valid and stays set; handshake -> HALT.
//  Undefined: no illegal_op port; unknown opcodes are passed as one-word instructions.
// STRUCTURE
//  Package isa_pkg: opcode localparams (loadim..endop), state enum typedef, function has_operand(opcode), function is_legal(opcode).
//  No sub-module; single FSM + pc register. isa_pkg is shared with the decoder.
// TESTING
//  1 mem[0]=38,mem[1]=257,mem[2]=9; fetch_en=1 -> opcode 38/operand 257/pc 0, then opcode 9/has_opnd 0/pc 2.
//  2 instr_ready=0 for 5 cycles while holding pc 2 -> outputs and imem_addr=3 stable; ready=1 -> next fetch from 3.
//  3 Redirect_valid with redirect_pc=127 while holding pc 2 -> instr_valid=0 next cycle; next instr_pc=127.
//  4 mem[126]=51 accepted -> halted=1, instr_valid stays 0 for 20 cycles despite fetch_en/redirect; rst clears.
//  5 Redirect to 0xFFFF with mem[0xFFFF]=38,mem[0]=5 -> operand 5; next instr_pc=0x0001.
//  6 rst pulsed during IMM -> outputs 0 asynchronously; fetch restarts at RESET_PC.
//  7 (IFETCH_ILLEGAL_TRAP_EN) mem[0]=16'h00AA -> illegal_op=1 with instr_valid; after handshake halted=1.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch stage and the decoder.
// Contents:
//   OP_* opcode codes that fetch and decode both need to know about
//   fetch_state_t  fetch FSM state encoding
//   has_operand()  1 when the opcode is followed by a 16-bit operand word
//   is_legal()     1 when the low opcode byte is inside the ISA code range
package isa_pkg;

  localparam logic [7:0] OP_LOADIM = 8'd38;
  localparam logic [7:0] OP_JUMPZ  = 8'd41;
  localparam logic [7:0] OP_JUMPNZ = 8'd48;
  localparam logic [7:0] OP_JUMP   = 8'd49;
  localparam logic [7:0] OP_ENDOP  = 8'd51;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPC,
    ST_IMM,
    ST_OUT,
    ST_HALT
  } fetch_state_t;

  function automatic logic has_operand(input logic [7:0] opcode);
    return (opcode == OP_LOADIM) || (opcode == OP_JUMPZ) ||
           (opcode == OP_JUMPNZ) || (opcode == OP_JUMP);
  endfunction

  // The ISA is densely packed: codes 0 through endop are assigned,
  // anything above endop is unused.
  function automatic logic is_legal(input logic [7:0] opcode);
    return opcode <= OP_ENDOP;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage placed directly after a 1-cycle registered instruction memory.
// Walks the PC, assembles opcode plus optional operand word, and hands
// complete instructions to the decoder over valid/ready. Execute-stage
// redirects reload the PC; an accepted endop halts fetching until reset.
//
// Optional build macro: IFETCH_ILLEGAL_TRAP_EN adds the illegal_op output.
// An opcode word outside the ISA, or with a nonzero upper byte, is then
// flagged alongside instr_valid and its handshake halts the stage.
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   asynchronous active-high reset
//   fetch_en        in   allow new fetches to start
//   imem_addr       out  instruction memory address (combinational)
//   imem_rdata      in   word for the address presented the cycle before
//   instr_valid     out  instruction outputs valid
//   instr_ready     in   decoder accepts the instruction
//   instr_opcode    out  low byte of the opcode word
//   instr_operand   out  operand word, 0 for one-word instructions
//   instr_has_opnd  out  instruction carried an operand word
//   instr_pc        out  address of the opcode word
//   redirect_valid  in   PC redirect from execute
//   redirect_pc     in   redirect target
//   halted          out  endop accepted, fetching stopped
//   illegal_op      out  (trap build only) illegal opcode seen, sticky
module instr_fetch
  import isa_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        instr_opcode,
  output logic [DATA_W-1:0] instr_operand,
  output logic              instr_has_opnd,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
`ifdef IFETCH_ILLEGAL_TRAP_EN
  ,
  output logic              illegal_op
`endif
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              op_illegal;
  logic              trap_halt;

  // While the opcode word is arriving the operand address is already
  // presented; every other state presents pc, which in OUT prefetches the
  // next opcode so a handshake can go straight to OPC.
  always_comb begin
    imem_addr = pc;
    if (state == ST_OPC) imem_addr = pc + ADDR_W'(1);
  end

`ifdef IFETCH_ILLEGAL_TRAP_EN
  assign op_illegal = (imem_rdata[DATA_W-1:8] != '0) || !is_legal(imem_rdata[7:0]);
  assign trap_halt  = illegal_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_op <= 1'b0;
    end else if (state == ST_OPC && !redirect_valid && op_illegal) begin
      illegal_op <= 1'b1;
    end
  end
`else
  logic unused_upper;
  assign op_illegal   = 1'b0;
  assign trap_halt    = 1'b0;
  assign unused_upper = ^imem_rdata[DATA_W-1:8];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      pc             <= RESET_PC;
      instr_valid    <= 1'b0;
      instr_opcode   <= '0;
      instr_operand  <= '0;
      instr_has_opnd <= 1'b0;
      instr_pc       <= '0;
      halted         <= 1'b0;
    end else if (redirect_valid && state != ST_HALT) begin
      // Redirect beats everything, including a same-cycle handshake: the
      // held instruction counts as consumed and its endop check is skipped.
      pc          <= redirect_pc;
      instr_valid <= 1'b0;
      state       <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fetch_en) state <= ST_OPC;
        end
        ST_OPC: begin
          instr_opcode <= imem_rdata[7:0];
          instr_pc     <= pc;
          // Illegal words are treated as one-word so the trap surfaces
          // without consuming a bogus operand.
          if (has_operand(imem_rdata[7:0]) && !op_illegal) begin
            state <= ST_IMM;
          end else begin
            pc             <= pc + ADDR_W'(1);
            instr_operand  <= '0;
            instr_has_opnd <= 1'b0;
            instr_valid    <= 1'b1;
            state          <= ST_OUT;
          end
        end
        ST_IMM: begin
          instr_operand  <= imem_rdata;
          instr_has_opnd <= 1'b1;
          pc             <= pc + ADDR_W'(2);
          instr_valid    <= 1'b1;
          state          <= ST_OUT;
        end
        ST_OUT: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (instr_opcode == OP_ENDOP || trap_halt) begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end else if (fetch_en) begin
              state <= ST_OPC;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_HALT: begin
          instr_valid <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  import isa_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic [15:0] instr_operand;
  logic        instr_has_opnd;
  logic [15:0] instr_pc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halted;
`ifdef IFETCH_ILLEGAL_TRAP_EN
  logic        illegal_op;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:65535];

  instr_fetch dut (
    .clk(clk),
    .rst(rst),
    .fetch_en(fetch_en),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_opcode(instr_opcode),
    .instr_operand(instr_operand),
    .instr_has_opnd(instr_has_opnd),
    .instr_pc(instr_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halted(halted)
`ifdef IFETCH_ILLEGAL_TRAP_EN
    ,
    .illegal_op(illegal_op)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within 20000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Returns the number of negedges waited until instr_valid rose.
  task automatic wait_valid(output int n);
    n = 0;
    while (instr_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (instr_valid !== 1'b1) chk("valid_timeout", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic accept();
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [15:0] opnd;
    logic        has;
    logic [15:0] pc;
    int          hold;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  initial begin
    int          n;
    logic        ok;
    logic [15:0] nxt;

    for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
    mem[0]  = 16'd38;   mem[1] = 16'd257; mem[2] = 16'd9;
    mem[3]  = 16'd49;   mem[4] = 16'h1234;
`ifdef IFETCH_ILLEGAL_TRAP_EN
    mem[5]  = 16'h0007;
`else
    mem[5]  = 16'hFF07;
`endif
    mem[6]  = 16'd41;   mem[7] = 16'hABCD;
    mem[8]  = 16'd48;   mem[9] = 16'd2;
    mem[10] = 16'd3;    mem[11] = 16'd9;
    mem[126] = 16'd51;  mem[127] = 16'd51;

    vecs[0] = '{8'd38, 16'd257,   1'b1, 16'd0,  0};
    vecs[1] = '{8'd9,  16'd0,     1'b0, 16'd2,  5};
    vecs[2] = '{8'd49, 16'h1234,  1'b1, 16'd3,  0};
    vecs[3] = '{8'd7,  16'd0,     1'b0, 16'd5,  2};
    vecs[4] = '{8'd41, 16'hABCD,  1'b1, 16'd6,  0};
    vecs[5] = '{8'd48, 16'd2,     1'b1, 16'd8,  1};
    vecs[6] = '{8'd3,  16'd0,     1'b0, 16'd10, 0};

    rst = 1'b1; fetch_en = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 16'd0;
    repeat (2) @(negedge clk);

    chk("rst_valid",   {31'd0, instr_valid}, 32'd0);
    chk("rst_opcode",  {24'd0, instr_opcode}, 32'd0);
    chk("rst_operand", {16'd0, instr_operand}, 32'd0);
    chk("rst_has",     {31'd0, instr_has_opnd}, 32'd0);
    chk("rst_pc",      {16'd0, instr_pc}, 32'd0);
    chk("rst_halted",  {31'd0, halted}, 32'd0);
    chk("rst_addr",    {16'd0, imem_addr}, 32'd0);

    rst = 1'b0;
    fetch_en = 1'b1;

    // Straight-line program, including a held instruction and upper-byte noise.
    for (int i = 0; i < NV; i++) begin
      wait_valid(n);
      if (i > 0) chk("latency", n, vecs[i].has ? 32'd2 : 32'd1);
      nxt = vecs[i].pc + (vecs[i].has ? 16'd2 : 16'd1);
      chk("opcode",  {24'd0, instr_opcode}, {24'd0, vecs[i].op});
      chk("operand", {16'd0, instr_operand}, {16'd0, vecs[i].opnd});
      chk("has",     {31'd0, instr_has_opnd}, {31'd0, vecs[i].has});
      chk("pc",      {16'd0, instr_pc}, {16'd0, vecs[i].pc});
      chk("prefetch_addr", {16'd0, imem_addr}, {16'd0, nxt});
      if (vecs[i].hold > 0) begin
        ok = 1'b1;
        for (int h = 0; h < vecs[i].hold; h++) begin
          @(negedge clk);
          if (instr_valid !== 1'b1 || instr_opcode !== vecs[i].op ||
              instr_operand !== vecs[i].opnd || instr_pc !== vecs[i].pc ||
              imem_addr !== nxt) ok = 1'b0;
        end
        chk("hold_stable", {31'd0, ok}, 32'd1);
      end
      accept();
    end

    // Redirect while holding an instruction.
    wait_valid(n);
    chk("pre_redirect_pc", {16'd0, instr_pc}, 32'd11);
    redirect_valid = 1'b1; redirect_pc = 16'd127;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("redirect_drop", {31'd0, instr_valid}, 32'd0);
    wait_valid(n);
    chk("redirect_pc", {16'd0, instr_pc}, 32'd127);
    chk("redirect_op", {24'd0, instr_opcode}, 32'd51);

    // Redirect coincident with handshake of an endop: no halt.
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'd126;
    @(negedge clk);
    instr_ready = 1'b0; redirect_valid = 1'b0;
    chk("coinc_halted", {31'd0, halted}, 32'd0);
    chk("coinc_valid",  {31'd0, instr_valid}, 32'd0);
    wait_valid(n);
    chk("endop_pc", {16'd0, instr_pc}, 32'd126);
    chk("endop_op", {24'd0, instr_opcode}, 32'd51);
    accept();
    chk("halted", {31'd0, halted}, 32'd1);

    ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      fetch_en = c[0];
      redirect_valid = c[1];
      redirect_pc = 16'd0;
      @(negedge clk);
      if (instr_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 16'd127) ok = 1'b0;
    end
    redirect_valid = 1'b0;
    chk("halt_sticky", {31'd0, ok}, 32'd1);

    fetch_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_clears_halt", {31'd0, halted}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Operand wraps from 0xFFFF to 0x0000; fetch_en drops mid-instruction.
    mem[16'hFFFF] = 16'd38;
    mem[0] = 16'd5;
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    @(negedge clk);
    redirect_valid = 1'b0;
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    wait_valid(n);
    chk("wrap_opcode",  {24'd0, instr_opcode}, 32'd38);
    chk("wrap_operand", {16'd0, instr_operand}, 32'd5);
    chk("wrap_pc",      {16'd0, instr_pc}, 32'hFFFF);
    chk("wrap_addr",    {16'd0, imem_addr}, 32'd1);
    accept();
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (instr_valid !== 1'b0) ok = 1'b0;
    end
    chk("fetch_en_off_idle", {31'd0, ok}, 32'd1);
    fetch_en = 1'b1;
    wait_valid(n);
    chk("after_wrap_pc",  {16'd0, instr_pc}, 32'd1);
    chk("after_wrap_op",  {24'd0, instr_opcode}, 32'd1);
    chk("after_wrap_has", {31'd0, instr_has_opnd}, 32'd0);

    // Reset asserted while the operand word is being fetched.
    fetch_en = 1'b0;
    do_reset();
    mem[0] = 16'd9; mem[1] = 16'd38; mem[2] = 16'd257;
    fetch_en = 1'b1;
    wait_valid(n);
    chk("r6_first_op", {24'd0, instr_opcode}, 32'd9);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    @(negedge clk);
    chk("r6_imm_opcode", {24'd0, instr_opcode}, 32'd38);
    #2;
    rst = 1'b1;
    #1;
    chk("r6_async_opcode", {24'd0, instr_opcode}, 32'd0);
    chk("r6_async_pc",     {16'd0, instr_pc}, 32'd0);
    chk("r6_async_addr",   {16'd0, imem_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_valid(n);
    chk("r6_restart_pc", {16'd0, instr_pc}, 32'd0);
    chk("r6_restart_op", {24'd0, instr_opcode}, 32'd9);

    // Opcode outside the ISA range.
    fetch_en = 1'b0;
    do_reset();
    mem[0] = 16'h00AA;
    fetch_en = 1'b1;
    wait_valid(n);
    chk("unk_opcode", {24'd0, instr_opcode}, 32'hAA);
    chk("unk_has",    {31'd0, instr_has_opnd}, 32'd0);
`ifdef IFETCH_ILLEGAL_TRAP_EN
    chk("illegal_flag", {31'd0, illegal_op}, 32'd1);
    accept();
    chk("illegal_halt", {31'd0, halted}, 32'd1);
`else
    accept();
    chk("unk_no_halt", {31'd0, halted}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
